// File: rtl/gate_tt_tester.sv
// gate_tt_tester: walks all four {a,b} vectors into a 2-input gate and checks the output against EXPECT_TT.
// Latency: each vector is held SETTLE_CYCLES cycles and sampled one cycle later; done pulses 4*(SETTLE_CYCLES+1)+1 cycles after start.
// Backpressure: none; start is only honoured in IDLE, and abort cancels a run in progress.
module gate_tt_tester #(
  // Expected gate output for each vector; bit index = {a,b}. The default is OR.
  parameter logic [3:0]  EXPECT_TT     = 4'b1110,
  // Number of cycles a vector is held before it is sampled. The legal range is 1..15.
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // The settle counter starts at 0, so the last settle cycle is SETTLE_CYCLES-1.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_fail;
  logic [2:0] r_err;

  logic       w_settle_last;
  logic       w_mismatch;
  logic [3:0] w_fail_next;
  logic [2:0] w_err_next;

  assign w_settle_last = (r_cnt == SETTLE_LAST);

  // dut_c is compared directly because the gate is combinational from our own registered dut_a/dut_b.
  assign w_mismatch = (dut_c != EXPECT_TT[r_idx]);

  // The fail vector after this sample, and its popcount, so that err_count and pass never lag behind fail_vec.
  always_comb begin
    w_fail_next        = r_fail;
    w_fail_next[r_idx] = w_mismatch;
    w_err_next         = {2'b00, w_fail_next[0]} + {2'b00, w_fail_next[1]}
                       + {2'b00, w_fail_next[2]} + {2'b00, w_fail_next[3]};
  end

  // Sequencer: IDLE -> (SETTLE -> SAMPLE) x4 -> DONE -> IDLE. Abort returns to IDLE and keeps partial results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 4'd0;
      r_err   <= 3'd0;
    end else if (abort) begin
      // An abort in IDLE also prevents a start that is requested in the same cycle.
      if (r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_a     <= 1'b0;
        r_b     <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_pass  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b1;
            r_pass  <= 1'b0;
            r_fail  <= 4'd0;
            r_err   <= 3'd0;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_settle_last) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_fail <= w_fail_next;
          r_err  <= w_err_next;
          if (r_idx == 2'd3) begin
            // Pass uses the updated vector, so it is already valid in the cycle where done is high.
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (w_fail_next == 4'd0);
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end else begin
            r_state      <= ST_SETTLE;
            r_idx        <= r_idx + 2'd1;
            {r_a, r_b}   <= r_idx + 2'd1;
            r_cnt        <= 4'd0;
          end
        end
        ST_DONE: begin
          // A start in this cycle is deliberately dropped; only IDLE accepts a start.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_a     = r_a;
  assign dut_b     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_fail;
  assign err_count = r_err;

endmodule

// File: doc/gate_tt_tester.md
Name: gate_tt_tester

Overview:
- Sequential stimulus/response engine for the 2-input gate-level blocks in this lab codebase.
- Drives both inputs of a combinational 2-input gate, walks all four input combinations, waits a settle interval, and samples the gate output.
- Compares each sample against a parameterised truth table and reports per-vector fail flags, an error count and an overall pass.
- Sits on the driving side of the gate's a/b -> c interface.

Parameters:
- EXPECT_TT, 4'b1110: expected output per vector; bit index = {a,b}. Default is OR.
- SETTLE_CYCLES, 2: cycles the vector is held before sampling. Legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request; sampled only in IDLE
- abort  input  1  synchronous cancel; highest priority after reset
- dut_a  output  1  gate input a; registered
- dut_b  output  1  gate input b; registered
- dut_c  input  1  gate output; sampled directly, no synchroniser (the DUT is combinational from registered dut_a/dut_b)
- busy  output  1  high from the cycle after start is accepted until the DONE cycle (exclusive)
- done  output  1  one-cycle pulse at the end of a run
- pass  output  1  1 when fail_vec == 0; valid when done rises; held until the next start
- fail_vec  output  4  bit k set if vector k mismatched; held until the next start
- err_count  output  3  popcount of fail_vec; held

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - dut_a=dut_b=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0
  - internal idx=0, cnt=0
- All state and output updates occur on the rising edge of clk only.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 and abort=0 (cycle 0):
  - next state SETTLE; idx=0, {dut_a,dut_b}=2'b00, cnt=0, busy=1
  - fail_vec, err_count and pass cleared to 0
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE, so the vector is held exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - fail_vec[idx] <= (dut_c != EXPECT_TT[idx]); err_count updated in the same cycle.
  - If idx==3, go to DONE.
  - Otherwise idx+1, {dut_a,dut_b} <= idx+1, cnt=0, go to SETTLE.
- Per-vector cost is SETTLE_CYCLES+1 cycles. Vector k enters SETTLE at cycle 1+k*(SETTLE_CYCLES+1).
- DONE:
  - Entered at cycle 4*(SETTLE_CYCLES+1)+1.
  - done=1, busy=0, pass <= (fail_vec==0), {dut_a,dut_b} <= 0.
  - Next cycle: IDLE, done=0.
- idx is 2 bits and never wraps mid-run; the DONE transition occurs on idx==3.
- start outside IDLE is ignored and not queued, including a start asserted during the DONE cycle.
- start held high continuously: a new run starts each time IDLE is re-entered.
- abort=1 in any non-IDLE state:
  - next state IDLE, dut_a=dut_b=0, busy=0, done stays 0.
  - fail_vec/err_count keep their partial values; pass=0.
- abort and start together in IDLE: abort wins, no run starts.
- rst_n low mid-run: immediate return to reset values; no done pulse.
- err_count is always equal to the popcount of fail_vec; maximum value is 4.

Test Plan:
- Correct OR DUT, defaults, start pulsed at cycle 0 -> dut_{a,b} sequence 00,01,10,11, each held 3 cycles; done pulses at cycle 13; pass=1, fail_vec=4'b0000, err_count=0; busy high cycles 1-12.
- dut_c tied 0, defaults -> done at cycle 13; fail_vec=4'b1110, err_count=3, pass=0.
- EXPECT_TT=4'b0111, SETTLE_CYCLES=1, NAND DUT -> done at cycle 9, pass=1; with dut_c stuck at 1 -> fail_vec=4'b1000, err_count=1.
- start re-pulsed at cycles 4 and 13 during run -> ignored, single done at cycle 13; start at cycle 14 -> new run, outputs cleared at cycle 14.
- abort at cycle 7, vector 10 settling -> cycle 8: IDLE, busy=0, dut_a=dut_b=0, no done pulse; fail_vec holds vectors 0-1 results.
- rst_n driven low asynchronously at mid-cycle 5 -> all outputs 0 immediately; after release, start -> normal run completes 13 cycles later.
